frame_update_controller: RTL and testbench
==========================================

Name: frame_update_controller

Overview:
- Sequences all display-state updates for the radar VGA overlay writer.
- Accepts rover location and orientation from the ultrasound/orientation logic over valid/ready handshakes, holding each in a one-deep pending buffer.
- Commits buffered data and the target switches atomically at each vsync falling edge.
- Then iteratively computes the display scale factor so rover and target both fit inside the grid.

Parameters:
- SCALE_MIN, 1, smallest allowed scale factor.
- SCALE_MAX, 15, largest allowed scale factor (must fit 4 bits).
- SCALE_DEFAULT, 10, scale factor at reset, and always when auto-scale is compiled out.
- GRID_RADIUS_LIMIT, 256, maximum allowed scaled radius in pixels.

Ports:
- vclock  in  1  65MHz pixel clock.
- reset  in  1  asynchronous, active-high reset.
- vsync  in  1  XVGA vertical sync, active low.
- loc_valid  in  1  location word offered.
- location  in  12  polar rover location {radius[11:4], angle[3:0]}.
- loc_ready  out  1  location buffer can accept.
- orient_valid  in  1  orientation offered.
- orientation  in  5  rover orientation code.
- orient_ready  out  1  orientation buffer can accept.
- target_location  in  12  polar target location from switches, same format as location.
- disp_location  out  12  committed rover location.
- disp_orientation  out  5  committed orientation.
- disp_target  out  12  committed target location.
- new_data  out  1  one-cycle pulse: new location committed this frame.
- orientation_ready  out  1  level: disp_orientation is valid for disp_location.
- scale_factor  out  4  grid scale for polar-to-pixel mapping.
- frame_done  out  1  one-cycle pulse when commit and scale computation finish.

Behaviour:
- Reset (async): disp_* = 0, new_data = 0, orientation_ready = 0, frame_done = 0, scale_factor = SCALE_DEFAULT, both pending flags cleared, FSM = IDLE, vsync_d = 1.
- Handshake:
  - loc_ready = !loc_pending && state != COMMIT.
  - A transfer occurs on a cycle with loc_valid && loc_ready; it sets loc_pending and stores the word.
  - Orientation uses the same rule independently.
  - Offers made while not ready are held off; data is never silently dropped.
- Edge detect: vsync_d registers vsync. fall = vsync_d & ~vsync.
- FSM IDLE: on fall, go to COMMIT. Otherwise stay.
- FSM COMMIT (1 cycle):
  - disp_target <= target_location, always.
  - If loc_pending: disp_location <= buffer; new_data pulses on the next cycle; loc_pending cleared.
  - If orient_pending: disp_orientation <= buffer; orientation_ready <= 1; orient_pending cleared.
  - If a location commits without an orientation: orientation_ready <= 0.
  - An orientation with no location leaves disp_location unchanged.
  - Next state is SCALE.
- FSM SCALE:
  - rmax = max(disp_location[11:4], disp_target[11:4]), captured on entry.
  - Trial S starts at SCALE_MAX.
  - Each cycle: if S*rmax (12-bit unsigned) <= GRID_RADIUS_LIMIT or S == SCALE_MIN, then scale_factor <= S and go to DONE. Otherwise decrement S.
  - Worst case is SCALE_MAX-SCALE_MIN+1 cycles.
- FSM DONE: frame_done pulses for 1 cycle, then IDLE.
- A vsync fall seen outside IDLE is ignored; no frame is queued. vsync low time far exceeds 20 cycles, so this does not occur in normal operation.
- Latency: fall at cycle N → disp_* updated at N+2 → scale_factor updated at N+3..N+17.
- Simultaneous accept and fall: the word accepted in the same cycle as fall is included in that commit.
- Reset mid-SCALE: scale_factor returns to SCALE_DEFAULT and pending data is lost.
- scale_factor holds its value outside SCALE; consumers treat it as stable from frame_done until the next fall.

Optional Feature:
- Macro: FRAME_UPDATE_AUTO_SCALE_EN.
- Defined: SCALE state as above.
- Undefined: COMMIT goes directly to DONE, scale_factor is constant SCALE_DEFAULT, and no multiplier or rmax logic is synthesized. frame_done then occurs at fall+2.

Test Plan:
- Reset mid-frame with loc_pending set → all outputs at reset values, loc_ready = 1, scale_factor = 10 while reset is high.
- location = {8'd20, 4'd3}, target radius 5, vsync falls:
  - disp_location = 0x143 at fall+2.
  - new_data pulses once.
  - Trials 15, 14, 13 fail (300, 280, 260); scale_factor = 12.
  - frame_done pulses.
- Two location offers before vsync → first accepted, loc_ready = 0, second stalled. After commit the second is accepted and commits on the next frame.
- Orientation 5'd7 with location in one frame → orientation_ready = 1. Next frame: location only → orientation_ready = 0 and disp_orientation holds 7.
- Both radii 0 → scale_factor = 15 after one SCALE cycle. Target radius 255 → scale_factor = 1 (SCALE_MIN floor).
- Build with FRAME_UPDATE_AUTO_SCALE_EN undefined → scale_factor stays 10 for all inputs, and frame_done pulses at fall+2.

Source files
------------

// File: rtl/frame_update_controller.sv
// frame_update_controller: commits rover/target display state at each vsync fall, then sizes the grid scale.
// Auto-scaling is built only when FRAME_UPDATE_AUTO_SCALE_EN is defined; otherwise scale_factor is fixed.
module frame_update_controller #(
    parameter int SCALE_MIN = 1,
    parameter int SCALE_MAX = 15,
    parameter int SCALE_DEFAULT = 10
`ifdef FRAME_UPDATE_AUTO_SCALE_EN
    ,
    parameter int GRID_RADIUS_LIMIT = 256
`endif
) (
    input  logic        vclock,
    input  logic        reset,
    input  logic        vsync,
    input  logic        loc_valid,
    input  logic [11:0] location,
    output logic        loc_ready,
    input  logic        orient_valid,
    input  logic [4:0]  orientation,
    output logic        orient_ready,
    input  logic [11:0] target_location,
    output logic [11:0] disp_location,
    output logic [4:0]  disp_orientation,
    output logic [11:0] disp_target,
    output logic        new_data,
    output logic        orientation_ready,
    output logic [3:0]  scale_factor,
    output logic        frame_done
);
    typedef enum logic [1:0] {IDLE, COMMIT, SCALE, DONE} state_t;
    localparam logic [3:0] SCALE_RESET = 4'(SCALE_DEFAULT < SCALE_MIN ? SCALE_MIN :
                                            SCALE_DEFAULT > SCALE_MAX ? SCALE_MAX : SCALE_DEFAULT);
    state_t      state, state_nx;
    logic        vsync_d, fall, loc_pending, orient_pending, scale_hit;
    logic [11:0] loc_buf;
    logic [4:0]  orient_buf;
    assign fall         = vsync_d & ~vsync;
    assign loc_ready    = !loc_pending && state != COMMIT;
    assign orient_ready = !orient_pending && state != COMMIT;
    assign frame_done   = state == DONE;
`ifdef FRAME_UPDATE_AUTO_SCALE_EN
    logic [3:0]  trial;
    logic [7:0]  rmax, loc_radius;
    logic [11:0] product;
    // rmax is taken from the values being committed so SCALE sees the new frame
    assign loc_radius = loc_pending ? loc_buf[11:4] : disp_location[11:4];
    assign product    = {8'd0, trial} * {4'd0, rmax};
    assign scale_hit  = product <= 12'(GRID_RADIUS_LIMIT) || trial == 4'(SCALE_MIN);
    always_ff @(posedge vclock or posedge reset) begin
        if (reset) begin
            scale_factor <= SCALE_RESET;
            trial        <= 4'(SCALE_MAX);
            rmax         <= '0;
        end else if (state == COMMIT) begin
            trial <= 4'(SCALE_MAX);
            rmax  <= loc_radius > target_location[11:4] ? loc_radius : target_location[11:4];
        end else if (state == SCALE) begin
            if (scale_hit) scale_factor <= trial;
            else trial <= trial - 4'd1;
        end
    end
`else
    assign scale_hit    = 1'b1;
    assign scale_factor = SCALE_RESET;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   state_nx = fall ? COMMIT : IDLE;
`ifdef FRAME_UPDATE_AUTO_SCALE_EN
            COMMIT: state_nx = SCALE;
`else
            COMMIT: state_nx = DONE;
`endif
            SCALE:  state_nx = scale_hit ? DONE : SCALE;
            DONE:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge vclock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            vsync_d           <= 1'b1;
            loc_pending       <= 1'b0;
            orient_pending    <= 1'b0;
            loc_buf           <= '0;
            orient_buf        <= '0;
            disp_location     <= '0;
            disp_orientation  <= '0;
            disp_target       <= '0;
            new_data          <= 1'b0;
            orientation_ready <= 1'b0;
        end else begin
            state    <= state_nx;
            vsync_d  <= vsync;
            new_data <= state == COMMIT && loc_pending;
            if (loc_valid && loc_ready) begin
                loc_pending <= 1'b1;
                loc_buf     <= location;
            end
            if (orient_valid && orient_ready) begin
                orient_pending <= 1'b1;
                orient_buf     <= orientation;
            end
            // ready is low in COMMIT, so clearing here cannot lose a transfer
            if (state == COMMIT) begin
                disp_target <= target_location;
                if (loc_pending) begin
                    disp_location <= loc_buf;
                    loc_pending   <= 1'b0;
                    if (!orient_pending) orientation_ready <= 1'b0;
                end
                if (orient_pending) begin
                    disp_orientation  <= orient_buf;
                    orientation_ready <= 1'b1;
                    orient_pending    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_frame_update_controller.sv
// tb_frame_update_controller: scoreboarded frame commits and scale results for frame_update_controller.
module tb_frame_update_controller;
    logic        vclock = 0, reset = 0, vsync = 1, loc_valid = 0, orient_valid = 0;
    logic [11:0] location = 0, target_location = 0;
    logic [4:0]  orientation = 0;
    logic        loc_ready, orient_ready, new_data, orientation_ready, frame_done;
    logic [11:0] disp_location, disp_target;
    logic [4:0]  disp_orientation;
    logic [3:0]  scale_factor;
    int vectors = 0, miscompares = 0;

    typedef struct {
        logic [11:0] loc;
        logic [4:0]  ori;
        logic        ordy;
        logic [11:0] tgt;
        logic [3:0]  scale;
        logic        nd;
        int          lat;
    } exp_t;
    exp_t sb[$];

    bit          m_loc_pend = 0, m_or_pend = 0, m_oready = 0;
    logic [11:0] m_loc_buf = 0, m_disp_loc = 0;
    logic [4:0]  m_or_buf = 0, m_disp_or = 0;

    frame_update_controller dut (
        .vclock(vclock), .reset(reset), .vsync(vsync),
        .loc_valid(loc_valid), .location(location), .loc_ready(loc_ready),
        .orient_valid(orient_valid), .orientation(orientation), .orient_ready(orient_ready),
        .target_location(target_location), .disp_location(disp_location),
        .disp_orientation(disp_orientation), .disp_target(disp_target),
        .new_data(new_data), .orientation_ready(orientation_ready),
        .scale_factor(scale_factor), .frame_done(frame_done)
    );

    always #5 vclock = ~vclock;

    task automatic tick;
        @(posedge vclock);
        #1;
    endtask

    function automatic logic [3:0] exp_scale(input logic [7:0] r);
`ifdef FRAME_UPDATE_AUTO_SCALE_EN
        for (int s = 15; s > 1; s--)
            if (s * int'(r) <= 256) return 4'(s);
        return 4'd1;
`else
        return 4'd10;
`endif
    endfunction

    task automatic offer_loc(input logic [11:0] v);
        vectors++;
        if (loc_ready !== !m_loc_pend) begin
            miscompares++;
            $display("FAIL loc_ready: got %b want %b", loc_ready, !m_loc_pend);
        end
        loc_valid = 1; location = v;
        tick;
        loc_valid = 0;
        if (!m_loc_pend) begin m_loc_pend = 1; m_loc_buf = v; end
    endtask

    task automatic offer_orient(input logic [4:0] v);
        vectors++;
        if (orient_ready !== !m_or_pend) begin
            miscompares++;
            $display("FAIL orient_ready: got %b want %b", orient_ready, !m_or_pend);
        end
        orient_valid = 1; orientation = v;
        tick;
        orient_valid = 0;
        if (!m_or_pend) begin m_or_pend = 1; m_or_buf = v; end
    endtask

    task automatic do_frame(input logic [11:0] tgt, input bit sim, input logic [11:0] sim_val);
        exp_t e;
        int nd, done_k;
        bit got;
        target_location = tgt;
        vsync = 0;
        if (sim) begin
            vectors++;
            if (loc_ready !== !m_loc_pend) begin
                miscompares++;
                $display("FAIL loc_ready_at_fall: got %b want %b", loc_ready, !m_loc_pend);
            end
            loc_valid = 1; location = sim_val;
            if (!m_loc_pend) begin m_loc_pend = 1; m_loc_buf = sim_val; end
        end
        e.nd = m_loc_pend;
        if (m_loc_pend) begin
            m_disp_loc = m_loc_buf; m_loc_pend = 0;
            if (!m_or_pend) m_oready = 0;
        end
        if (m_or_pend) begin m_disp_or = m_or_buf; m_oready = 1; m_or_pend = 0; end
        e.loc = m_disp_loc; e.ori = m_disp_or; e.ordy = m_oready; e.tgt = tgt;
        e.scale = exp_scale(m_disp_loc[11:4] > tgt[11:4] ? m_disp_loc[11:4] : tgt[11:4]);
`ifdef FRAME_UPDATE_AUTO_SCALE_EN
        e.lat = 18 - int'(e.scale);
`else
        e.lat = 2;
`endif
        sb.push_back(e);
        nd = 0; got = 0; done_k = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            tick;
            loc_valid = 0;
            if (new_data) nd++;
            if (k == 2) begin
                vectors++;
                if (disp_location !== sb[0].loc || disp_target !== sb[0].tgt) begin
                    miscompares++;
                    $display("FAIL disp_at_fall+2: got %h/%h want %h/%h", disp_location, disp_target, sb[0].loc, sb[0].tgt);
                end
            end
            if (frame_done) begin got = 1; done_k = k; end
        end
        e = sb.pop_front();
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL frame_done_timeout: got none want pulse at fall+%0d", e.lat);
        end else begin
            if (done_k != e.lat) begin
                miscompares++;
                $display("FAIL frame_done_latency: got fall+%0d want fall+%0d", done_k, e.lat);
            end
            vectors++;
            if ({disp_location, disp_orientation, orientation_ready, disp_target} !== {e.loc, e.ori, e.ordy, e.tgt}) begin
                miscompares++;
                $display("FAIL commit: got loc=%h ori=%h ordy=%b tgt=%h want loc=%h ori=%h ordy=%b tgt=%h",
                         disp_location, disp_orientation, orientation_ready, disp_target, e.loc, e.ori, e.ordy, e.tgt);
            end
            vectors++;
            if (scale_factor !== e.scale) begin
                miscompares++;
                $display("FAIL scale_factor: got %0d want %0d", scale_factor, e.scale);
            end
            vectors++;
            if (nd != int'(e.nd)) begin
                miscompares++;
                $display("FAIL new_data_pulses: got %0d want %0d", nd, e.nd);
            end
            tick;
            vectors++;
            if ({frame_done, new_data} !== 2'b00) begin
                miscompares++;
                $display("FAIL pulse_width: got done=%b nd=%b want 0/0", frame_done, new_data);
            end
        end
        vsync = 1;
        tick;
        tick;
    endtask

    task automatic test_reset;
        #1 reset = 1;
        tick;
        tick;
        vectors++;
        if ({disp_location, disp_orientation, disp_target} !== 29'd0) begin
            miscompares++;
            $display("FAIL reset_disp: got %h %h %h want 0", disp_location, disp_orientation, disp_target);
        end
        vectors++;
        if ({new_data, orientation_ready, frame_done, loc_ready, orient_ready} !== 5'b00011) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 00011", {new_data, orientation_ready, frame_done, loc_ready, orient_ready});
        end
        vectors++;
        if (scale_factor !== 4'd10) begin
            miscompares++;
            $display("FAIL reset_scale: got %0d want 10", scale_factor);
        end
        reset = 0;
        tick;
    endtask

    task automatic test_scale;
        offer_loc(12'h143);
        do_frame(12'h05A, 0, 12'h000);
        vectors++;
`ifdef FRAME_UPDATE_AUTO_SCALE_EN
        if (scale_factor !== 4'd12 || disp_location !== 12'h143) begin
`else
        if (scale_factor !== 4'd10 || disp_location !== 12'h143) begin
`endif
            miscompares++;
            $display("FAIL scale_r20: got scale=%0d loc=%h", scale_factor, disp_location);
        end
    endtask

    task automatic test_back_to_back;
        offer_loc(12'h2A1);
        offer_loc(12'h3B2);
        tick;
        vectors++;
        if (loc_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold: got loc_ready=%b want 0", loc_ready);
        end
        do_frame(12'h010, 0, 12'h000);
        offer_loc(12'h3B2);
        do_frame(12'h010, 0, 12'h000);
    endtask

    task automatic test_orientation;
        offer_orient(5'd7);
        offer_loc(12'h0C5);
        do_frame(12'h030, 0, 12'h000);
        offer_loc(12'h0D6);
        do_frame(12'h030, 0, 12'h000);
        vectors++;
        if (orientation_ready !== 1'b0 || disp_orientation !== 5'd7) begin
            miscompares++;
            $display("FAIL orient_stale: got ordy=%b ori=%0d want 0/7", orientation_ready, disp_orientation);
        end
        offer_orient(5'd3);
        do_frame(12'h030, 0, 12'h000);
    endtask

    task automatic test_scale_bounds;
        offer_loc(12'h000);
        do_frame(12'h000, 0, 12'h000);
        do_frame(12'hFF0, 0, 12'h000);
        vectors++;
`ifdef FRAME_UPDATE_AUTO_SCALE_EN
        if (scale_factor !== 4'd1) begin
`else
        if (scale_factor !== 4'd10) begin
`endif
            miscompares++;
            $display("FAIL scale_floor: got %0d", scale_factor);
        end
    endtask

    task automatic test_simultaneous;
        do_frame(12'h020, 1, 12'h8A4);
    endtask

    task automatic test_reset_mid;
        offer_loc(12'h500);
        target_location = 12'hFF0;
        vsync = 0;
        tick;
        tick;
        m_loc_pend = 0;
        offer_loc(12'h777);
        vectors++;
        if (loc_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pending_before_reset: got loc_ready=%b want 0", loc_ready);
        end
        #2 reset = 1;
        #1;
        vectors++;
        if ({disp_location, disp_orientation, disp_target, new_data, orientation_ready, frame_done} !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h %h %h %b%b%b want 0", disp_location, disp_orientation,
                     disp_target, new_data, orientation_ready, frame_done);
        end
        vectors++;
        if ({loc_ready, orient_ready, scale_factor} !== {2'b11, 4'd10}) begin
            miscompares++;
            $display("FAIL midreset_ready_scale: got %b%b %0d want 11 10", loc_ready, orient_ready, scale_factor);
        end
        vsync = 1;
        tick;
        reset = 0;
        tick;
        m_loc_pend = 0; m_or_pend = 0; m_oready = 0; m_disp_loc = 0; m_disp_or = 0;
        offer_loc(12'h143);
        do_frame(12'h05A, 0, 12'h000);
    endtask

    initial begin
        test_reset;
        test_scale;
        test_back_to_back;
        test_orientation;
        test_scale_bounds;
        test_simultaneous;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end
endmodule
